// File: rtl/alu_mc_pkg.sv
// Shared opcode encoding, FSM state type and opcode-class predicates for the
// multi-cycle ALU.
package alu_mc_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_DIVU = 4'b1010,
    OP_RSVD = 4'b1011,
    OP_DIV  = 4'b1100,
    OP_SRA  = 4'b1101,
    OP_REM  = 4'b1110,
    OP_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input logic [ALU_OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input logic [ALU_OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [ALU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op == OP_MUL) || is_div(op);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply (low half) or restoring
// divide, one bit per cycle; sign handling is done by the parent.
module alu_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic [ALU_OP_W-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] res
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                  active_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [ALU_OP_W-1:0]   op_r;
  logic [DATA_WIDTH-1:0] acc_r, x_r, y_r;
  logic [DATA_WIDTH-1:0] acc_n_s, x_n_s, y_n_s;
  logic [DATA_WIDTH:0]   sh_s, diff_s;

  // MUL: acc += x when y[0]; x <<= 1; y >>= 1.
  // DIV: x shifts the dividend out into acc and the quotient bits in.
  always_comb begin
    sh_s   = {acc_r, x_r[DATA_WIDTH-1]};
    diff_s = sh_s - {1'b0, y_r};
    if (op_r == OP_MUL) begin
      acc_n_s = acc_r + (y_r[0] ? x_r : '0);
      x_n_s   = {x_r[DATA_WIDTH-2:0], 1'b0};
      y_n_s   = {1'b0, y_r[DATA_WIDTH-1:1]};
    end else if (!diff_s[DATA_WIDTH]) begin
      acc_n_s = diff_s[DATA_WIDTH-1:0];
      x_n_s   = {x_r[DATA_WIDTH-2:0], 1'b1};
      y_n_s   = y_r;
    end else begin
      acc_n_s = sh_s[DATA_WIDTH-1:0];
      x_n_s   = {x_r[DATA_WIDTH-2:0], 1'b0};
      y_n_s   = y_r;
    end
  end

  // Final-step result selection: quotient for DIV/DIVU, accumulator otherwise.
  always_comb begin
    if (is_div(op_r) && !is_rem(op_r)) begin
      res = x_n_s;
    end else begin
      res = acc_n_s;
    end
  end

  assign done = active_r && (cnt_r == CNT_LAST);

  // Iteration state and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
      op_r     <= '0;
      acc_r    <= '0;
      x_r      <= '0;
      y_r      <= '0;
    end else if (clear) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= '0;
      op_r     <= op;
      acc_r    <= '0;
      x_r      <= a;
      y_r      <= b;
    end else if (active_r) begin
      acc_r <= acc_n_s;
      x_r   <= x_n_s;
      y_r   <= y_n_s;
      if (done) begin
        active_r <= 1'b0;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake FSM, single-cycle ops and divide
// special cases here; MUL/DIV iterations delegated to alu_muldiv_iter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int SHAMT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   src1,
  input  logic [DATA_WIDTH-1:0]   src2,
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    busy
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                  state_r;
  logic                    neg_r;
  logic [SHAMT_WIDTH-1:0]  shamt_s;
  logic [DATA_WIDTH-1:0]   simple_s, spec_res_s, accept_res_s;
  logic [DATA_WIDTH-1:0]   a_mag_s, b_mag_s, it_res_s;
  logic                    div0_s, ovf_s, special_s, go_iter_s, neg_n_s;
  logic                    start_s, it_done_s;

  assign shamt_s = src2[SHAMT_WIDTH-1:0];

  // Single-cycle datapath; reserved opcode falls through to zero.
  always_comb begin
    case (alu_op)
      OP_ADD:  simple_s = src1 + src2;
      OP_SUB:  simple_s = src1 - src2;
      OP_SLL:  simple_s = src1 << shamt_s;
      OP_SLT:  simple_s = {{(DATA_WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: simple_s = {{(DATA_WIDTH-1){1'b0}}, src1 < src2};
      OP_XOR:  simple_s = src1 ^ src2;
      OP_SRL:  simple_s = src1 >> shamt_s;
      OP_SRA:  simple_s = $unsigned($signed(src1) >>> shamt_s);
      OP_OR:   simple_s = src1 | src2;
      OP_AND:  simple_s = src1 & src2;
      default: simple_s = '0;
    endcase
  end

  assign div0_s    = is_div(alu_op) && (src2 == '0);
  assign ovf_s     = is_signed_div(alu_op) && (src1 == MOST_NEG) && (src2 == '1);
  assign special_s = div0_s || ovf_s;
  assign go_iter_s = is_muldiv(alu_op) && !special_s;

  // Divide-by-zero and signed-overflow results, finished without iterating.
  always_comb begin
    if (div0_s) begin
      spec_res_s = is_rem(alu_op) ? src1 : '1;
    end else if (ovf_s) begin
      spec_res_s = is_rem(alu_op) ? '0 : src1;
    end else begin
      spec_res_s = '0;
    end
  end

  assign accept_res_s = special_s ? spec_res_s : simple_s;

  // Operand magnitudes and the final negate flag for signed divide.
  always_comb begin
    if (is_signed_div(alu_op)) begin
      a_mag_s = src1[DATA_WIDTH-1] ? -src1 : src1;
      b_mag_s = src2[DATA_WIDTH-1] ? -src2 : src2;
      neg_n_s = is_rem(alu_op) ? src1[DATA_WIDTH-1]
                               : (src1[DATA_WIDTH-1] ^ src2[DATA_WIDTH-1]);
    end else begin
      a_mag_s = src1;
      b_mag_s = src2;
      neg_n_s = 1'b0;
    end
  end

  assign start_s = (state_r == ST_IDLE) && in_valid && !flush && go_iter_s;

  alu_muldiv_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .start (start_s),
    .op    (alu_op),
    .a     (a_mag_s),
    .b     (b_mag_s),
    .done  (it_done_s),
    .res   (it_res_s)
  );

  // Handshake FSM; flush aborts but leaves the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      neg_r     <= 1'b0;
    end else if (flush) begin
      state_r   <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (go_iter_s) begin
              state_r <= ST_BUSY;
              neg_r   <= neg_n_s;
            end else begin
              state_r   <= ST_DONE;
              result    <= accept_res_s;
              out_valid <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (it_done_s) begin
            result    <= neg_r ? -it_res_s : it_res_s;
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at DATA_WIDTH=32: latency, results,
// backpressure, flush and mid-operation reset.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [31:0] src1, src2, result;
  logic [3:0]  alu_op;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  bit   seen, flag;

  always #5 clk = ~clk;

  alu_mc #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_op    (alu_op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accepting posedge (cycle 0).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    alu_op   = op;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
    int  c;
    bit  s;
    c = 0;
    s = 1'b0;
    while (!s && c < 40) begin
      @(negedge clk);
      c++;
      if (out_valid === 1'b1) s = 1'b1;
    end
    chk({tag, "_lat"}, 32'(c), 32'(exp_lat));
    chk(tag, result, exp);
    @(negedge clk);
    chk({tag, "_single"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    src1 = 32'd0; src2 = 32'd0; alu_op = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);  wait_result("add_wrap", 32'h0, 1);
    issue(OP_SUB, 32'd5, 32'd7);          wait_result("sub", 32'hFFFF_FFFE, 1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);  wait_result("slt", 32'd1, 1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1); wait_result("sltu", 32'd0, 1);
    issue(OP_SRA, 32'h8000_0000, 32'h24); wait_result("sra", 32'hF800_0000, 1);
    issue(OP_SRL, 32'h8000_0000, 32'h24); wait_result("srl", 32'h0800_0000, 1);
    issue(OP_SLL, 32'd1, 32'd31);         wait_result("sll", 32'h8000_0000, 1);
    issue(OP_RSVD, 32'd9, 32'd9);         wait_result("rsvd", 32'd0, 1);

    // MUL with in_ready watched throughout, then 5 cycles of backpressure.
    out_ready = 1'b0;
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3);
    cyc = 0; seen = 1'b0; flag = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (in_ready !== 1'b0) flag = 1'b1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("mul_lat", 32'(cyc), 32'd33);
    chk("mul", result, 32'hFFFF_FFFD);
    chk("mul_ready_low", 32'(flag), 32'd0);
    alu_op = OP_ADD; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1;
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFD || in_ready !== 1'b0) flag = 1'b1;
    end
    chk("backpressure_hold", 32'(flag), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);  wait_result("div_neg", 32'hFFFF_FFFD, 33);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2);  wait_result("rem_neg", 32'hFFFF_FFFF, 33);
    issue(OP_DIVU, 32'd7, 32'd0);         wait_result("divu_by0", 32'hFFFF_FFFF, 1);
    issue(OP_REMU, 32'd7, 32'd0);         wait_result("remu_by0", 32'd7, 1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("div_ovf", 32'h8000_0000, 1);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("rem_ovf", 32'd0, 1);

    // Flush a DIVU in cycle 10; the stale result must never appear.
    issue(OP_DIVU, 32'd100, 32'd7);
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) flag = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_kept", result, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) flag = 1'b1;
    end
    chk("flush_no_valid", 32'(flag), 32'd0);
    alu_op = OP_ADD; src1 = 32'd9; src2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", 32'(out_valid), 32'd0);
    chk("flush_blocks_ready", 32'(in_ready), 32'd1);
    issue(OP_ADD, 32'd2, 32'd3);          wait_result("add_after_flush", 32'd5, 1);

    // Reset while BUSY.
    issue(OP_MUL, 32'd12345, 32'd678);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MUL, 32'd12345, 32'd678);    wait_result("b2b_mul", 32'h007F_B6F6, 33);
    issue(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF); wait_result("b2b_xor", 32'h5555_5555, 1);
    issue(OP_DIVU, 32'd100, 32'd7);       wait_result("b2b_divu", 32'd14, 33);
    issue(OP_REMU, 32'd100, 32'd7);       wait_result("b2b_remu", 32'd2, 33);
    issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F); wait_result("b2b_or", 32'hF0F0_0F0F, 1);
    issue(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F); wait_result("b2b_and", 32'h0F00_0F00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the NPC execute stage; successor to the single-cycle integer ALU.
- Adds subtract, set-less-than, shifts, iterative multiply (low half) and signed/unsigned divide/remainder.
- Operand and result paths use valid/ready handshakes so the pipeline stalls while a long op runs.
- Results are registered: every op has at least 1 cycle latency.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, >= 8.
- ALU_OP_WIDTH, 4, opcode width; fixed at 4 for this encoding.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), number of shift-amount bits taken from src2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands and op are valid
- in_ready  out  1  block can accept an op; high only in IDLE
- src1  in  DATA_WIDTH  operand 1
- src2  in  DATA_WIDTH  operand 2
- alu_op  in  ALU_OP_WIDTH  operation select
- flush  in  1  synchronous abort of any in-flight op
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result
- result  out  DATA_WIDTH  registered result
- busy  out  1  state != IDLE

Behaviour:
- Opcodes: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111, MUL=1001, DIVU=1010, DIV=1100, REM=1110, REMU=1111.
- Undefined opcode 1011 completes as a simple op with result 0.
- Reset values (async, rst_n low): state=IDLE, out_valid=0, result=0, busy=0, counter=0. in_ready=1 once in IDLE.
- States:
  - IDLE: accept on in_valid & in_ready.
    - Simple op, or a MUL/DIV-class special case: result computed and registered, go to DONE.
    - MUL/DIV-class op otherwise: latch operand magnitudes and sign flags, counter=0, go to BUSY.
  - BUSY: one iteration per cycle.
    - MUL: shift-add, 1 bit per cycle.
    - DIV-class: restoring divide, 1 quotient bit per cycle.
    - After DATA_WIDTH iterations, apply sign correction, write result, go to DONE.
  - DONE: out_valid=1 and result held stable until out_ready. On out_valid & out_ready go to IDLE, out_valid=0 next cycle.
- Latency (accept at cycle 0):
  - Simple ops: out_valid at cycle 1.
  - MUL/DIV-class: out_valid at cycle DATA_WIDTH+1.
- Throughput: one op in flight; in_ready=0 in BUSY and DONE, including the handshake cycle itself.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH. SLT is signed, SLTU unsigned; both give result 0 or 1, zero-extended.
- Shifts: amount = src2[SHAMT_WIDTH-1:0]; SRA sign-fills.
- MUL: low DATA_WIDTH bits of the product; sign-agnostic.
- Divide by zero (1-cycle special case): DIV/DIVU give all ones; REM/REMU give src1.
- Signed overflow, DIV/REM with src1=most-negative and src2=-1 (1-cycle special case): DIV gives src1, REM gives 0.
- Signed div/rem: quotient negated if operand signs differ; remainder takes the sign of src1.
- flush:
  - Has priority over everything else: next state IDLE, out_valid=0, counter cleared, result unchanged.
  - A handshake offered in the same cycle as flush is not accepted.
- Reset mid-BUSY or mid-DONE: immediate return to reset values; the partial result is discarded.
- Inputs are sampled only at acceptance; src1/src2/alu_op may change during BUSY without effect.

Decomposition:
- Shared package/header alu_pkg.vh: opcode constants (OP_*), ALU_OP_WIDTH, helper predicate macro for MUL/DIV-class opcodes.
- Sub-module alu_muldiv_iter holds the iterative shift-add/restore datapath and counter.
  - Interface: start, op, a, b, done, res.
  - alu_mc owns the handshake FSM, the simple-op datapath and the special cases.

Test Plan (DATA_WIDTH=32):
- ADD 0xFFFFFFFF+1 -> result 0x00000000, out_valid at cycle 1. SUB 5-7 -> 0xFFFFFFFE. SLT(-1,1)=1, SLTU(0xFFFFFFFF,1)=0.
- SRA 0x80000000 by src2=0x24 -> shift 4 -> 0xF8000000. SRL same operands -> 0x08000000. SLL 1 by 31 -> 0x80000000.
- MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD at cycle 33, with in_ready=0 during cycles 1-33. Backpressure out_ready=0 for 5 cycles -> result held, no new accept.
- DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF at cycle 1. REM 0x80000000 by -1 -> 0.
- Accept DIVU 100/7, assert flush at cycle 10 -> out_valid never rises for that op, in_ready=1 at cycle 11. Next ADD 2+3 -> 5.
- Assert rst_n=0 mid-BUSY -> out_valid=0, busy=0 immediately. After release, back-to-back ops with out_ready=1 -> one result per completion, none lost or duplicated.
